// File: rtl/io_mmio_hub_if.sv
// Load/store bus between the CPU data path and the I/O hub.
// The CPU side is the master; rdata is registered inside the hub.
interface io_mmio_hub_if;
  logic        io_sel;
  logic [4:0]  addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output io_sel, addr, rd_en, wr_en, wdata, input rdata);
  modport slave  (input io_sel, addr, rd_en, wr_en, wdata, output rdata);
endinterface

// File: rtl/io_mmio_hub.sv
// Memory-mapped switches, confirm button, LEDs and scanned seven-segment banks
// for the single-cycle CPU, with a 1-cycle registered read port.
module io_mmio_hub #(
  parameter int SW_W     = 8,
  parameter int CASE_W   = 4,
  parameter int LED_W    = 8,
  parameter int GROUPS   = 2,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  io_mmio_hub_if.slave          bus,
  input  logic [SW_W-1:0]       sw_data,
  input  logic [CASE_W-1:0]     sw_case,
  input  logic                  confirm,
  output logic [LED_W-1:0]      led,
  output logic [8*GROUPS-1:0]   seg,
  output logic [4*GROUPS-1:0]   sel
);

  localparam int DIGITS = 4 * GROUPS;
  localparam int CNT_W  = $clog2(SCAN_DIV);

  localparam logic [2:0] W_SW_DATA  = 3'd0;
  localparam logic [2:0] W_SW_CASE  = 3'd1;
  localparam logic [2:0] W_CONFIRM  = 3'd2;
  localparam logic [2:0] W_LED      = 3'd3;
  localparam logic [2:0] W_SEG_VAL  = 3'd4;
  localparam logic [2:0] W_SEG_CTRL = 3'd5;

  logic [SW_W-1:0]      sw_data_m, sw_data_s;
  logic [CASE_W-1:0]    sw_case_m, sw_case_s;
  logic                 confirm_m, confirm_s, confirm_d;
  logic                 pending, overrun;
  logic [LED_W-1:0]     led_q;
  logic [16*GROUPS-1:0] seg_val;
  logic                 disp_en;
  logic [DIGITS-1:0]    dp_mask;
  logic [CNT_W-1:0]     scan_cnt;
  logic [1:0]           dig_idx;
  logic                 refresh, disp_on;
  logic [31:0]          rd_mux;
  logic [8*GROUPS-1:0]  seg_nxt;
  logic [4*GROUPS-1:0]  sel_nxt;
  logic [16*GROUPS-1:0] val_sh;
  logic [DIGITS-1:0]    dp_sh;

  wire [2:0] word      = bus.addr[4:2];
  wire       rd_hit    = bus.io_sel & bus.rd_en;
  wire       wr_hit    = bus.io_sel & bus.wr_en;
  wire       conf_edge = confirm_s & ~confirm_d;
  wire       scan_wrap = (scan_cnt == CNT_W'(SCAN_DIV - 1));
  wire       unused_bits = ^{bus.addr[1:0], bus.wdata};

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; this is also what gives read-before-write on a same-cycle hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_data_m <= '0;  sw_data_s <= '0;
      sw_case_m <= '0;  sw_case_s <= '0;
      confirm_m <= 1'b0; confirm_s <= 1'b0; confirm_d <= 1'b0;
    end else begin
      sw_data_m <= sw_data;  sw_data_s <= sw_data_m;
      sw_case_m <= sw_case;  sw_case_s <= sw_case_m;
      confirm_m <= confirm;  confirm_s <= confirm_m; confirm_d <= confirm_s;
    end
  end

  // A clearing read and a new edge in the same cycle leave only pending set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (rd_hit && word == W_CONFIRM) begin
      pending <= conf_edge;
      overrun <= 1'b0;
    end else if (conf_edge) begin
      if (pending) overrun <= 1'b1;
      else         pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q   <= '0;
      seg_val <= '0;
      disp_en <= 1'b0;
      dp_mask <= '0;
    end else if (wr_hit) begin
      case (word)
        W_LED:     led_q   <= bus.wdata[LED_W-1:0];
        W_SEG_VAL: seg_val <= bus.wdata[16*GROUPS-1:0];
        W_SEG_CTRL: begin
          disp_en <= bus.wdata[0];
          dp_mask <= bus.wdata[DIGITS+3:4];
        end
        default: ;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    rd_mux = '0;
    case (word)
      W_SW_DATA:  rd_mux[SW_W-1:0]   = sw_data_s;
      W_SW_CASE:  rd_mux[CASE_W-1:0] = sw_case_s;
      W_CONFIRM:  rd_mux[1:0]        = {overrun, pending};
      W_LED:      rd_mux[LED_W-1:0]  = led_q;
      W_SEG_VAL:  rd_mux[16*GROUPS-1:0] = seg_val;
      W_SEG_CTRL: begin
        rd_mux[0]          = disp_en;
        rd_mux[DIGITS+3:4] = dp_mask;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bus.rdata <= '0;
    else if (rd_hit) bus.rdata <= rd_mux;
  end

  // The scan keeps running while the display is disabled so re-enable resumes in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
      refresh  <= 1'b0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) dig_idx <= dig_idx + 2'd1;
      refresh <= scan_wrap;
    end
  end

  always_comb begin
    val_sh  = seg_val >> {dig_idx, 2'b00};
    dp_sh   = dp_mask >> dig_idx;
    seg_nxt = '0;
    sel_nxt = '0;
    for (int b = 0; b < GROUPS; b++) begin
      seg_nxt[8*b +: 8] = {dp_sh[4*b], hex7(val_sh[16*b +: 4])};
      sel_nxt[4*b +: 4] = 4'b0001 << dig_idx;
    end
  end

  // Digits load only at a refresh (or first cycle after enable), so SEG_VAL writes never glitch mid-digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= '0;
      sel     <= '0;
      disp_on <= 1'b0;
    end else if (!disp_en) begin
      seg     <= '0;
      sel     <= '0;
      disp_on <= 1'b0;
    end else if (refresh || !disp_on) begin
      seg     <= seg_nxt;
      sel     <= sel_nxt;
      disp_on <= 1'b1;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_io_mmio_hub.sv
// Directed checks of the I/O hub: reset, bus map, synchronisers, confirm
// handshake and the display scan with a short scan period.
module tb_io_mmio_hub;

  logic        fpga_clk;
  logic        rst_n;
  logic [7:0]  sw_data;
  logic [3:0]  sw_case;
  logic        confirm;
  logic [7:0]  led;
  logic [15:0] seg;
  logic [7:0]  sel;
  logic [31:0] rd;
  int          n_checks;
  int          n_fail;

  io_mmio_hub_if bus ();

  io_mmio_hub #(
    .SW_W(8), .CASE_W(4), .LED_W(8), .GROUPS(2), .SCAN_DIV(4)
  ) dut (
    .clk(fpga_clk), .rst_n(rst_n), .bus(bus),
    .sw_data(sw_data), .sw_case(sw_case), .confirm(confirm),
    .led(led), .seg(seg), .sel(sel)
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] w, input logic [31:0] data);
    @(negedge fpga_clk);
    bus.io_sel = 1'b1; bus.addr = {w, 2'b00}; bus.wdata = data; bus.wr_en = 1'b1;
    @(negedge fpga_clk);
    bus.io_sel = 1'b0; bus.wr_en = 1'b0; bus.wdata = '0;
  endtask

  task automatic bus_read(input logic [2:0] w, output logic [31:0] data);
    @(negedge fpga_clk);
    bus.io_sel = 1'b1; bus.addr = {w, 2'b11}; bus.rd_en = 1'b1;
    @(negedge fpga_clk);
    bus.io_sel = 1'b0; bus.rd_en = 1'b0;
    data = bus.rdata;
  endtask

  task automatic pulse_confirm();
    @(negedge fpga_clk); confirm = 1'b1;
    repeat (3) @(negedge fpga_clk);
    confirm = 1'b0;
    repeat (4) @(negedge fpga_clk);
  endtask

  task automatic wait_sel(input string tag, input logic [7:0] want);
    int n = 0;
    while (sel !== want && n < 40) begin
      @(negedge fpga_clk);
      n++;
    end
    check(tag, 32'(sel), 32'(want));
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; sw_data = 8'h00; sw_case = 4'h0; confirm = 1'b0;
    bus.io_sel = 1'b0; bus.addr = '0; bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.wdata = '0;

    // 1: strobes are ignored while reset is held
    @(negedge fpga_clk);
    bus.io_sel = 1'b1; bus.addr = 5'h0C; bus.wdata = 32'hFF; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
    repeat (2) @(negedge fpga_clk);
    bus.io_sel = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    check("rst_led", 32'(led), 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_seg", 32'(seg), 32'h0);
    rst_n = 1'b1;
    bus_write(3'd3, 32'hFFFF_FFA5);
    check("led_out", 32'(led), 32'hA5);
    bus_read(3'd3, rd);
    check("led_read", rd, 32'h0000_00A5);
    repeat (3) @(negedge fpga_clk);
    check("rdata_hold", bus.rdata, 32'h0000_00A5);

    // 2: switch synchroniser latency
    sw_data = 8'h3C; sw_case = 4'h9;
    repeat (3) @(negedge fpga_clk);
    bus_read(3'd0, rd);
    check("sw_data", rd, 32'h3C);
    bus_read(3'd1, rd);
    check("sw_case", rd, 32'h9);
    @(negedge fpga_clk); sw_data = 8'h55;
    bus_read(3'd0, rd);
    check("sw_data_early", rd, 32'h3C);
    bus_read(3'd0, rd);
    check("sw_data_late", rd, 32'h55);

    // 3: confirm handshake
    pulse_confirm();
    pulse_confirm();
    bus_read(3'd2, rd);
    check("conf_overrun", rd, 32'h3);
    bus_read(3'd2, rd);
    check("conf_cleared", rd, 32'h0);
    pulse_confirm();
    @(negedge fpga_clk); confirm = 1'b1;
    @(negedge fpga_clk);
    bus_read(3'd2, rd);          // edge lands on the clearing read
    check("conf_race_ret", rd, 32'h1);
    confirm = 1'b0;
    repeat (4) @(negedge fpga_clk);
    bus_read(3'd2, rd);
    check("conf_race_after", rd, 32'h1);
    bus_read(3'd2, rd);
    check("conf_race_clear", rd, 32'h0);

    // 4: display scan, SCAN_DIV=4
    bus_write(3'd4, 32'h1234_5678);
    bus_write(3'd5, 32'h0000_0011);
    bus_read(3'd4, rd);
    check("segval_read", rd, 32'h1234_5678);
    bus_read(3'd5, rd);
    check("segctrl_read", rd, 32'h11);
    wait_sel("scan_sync_22", 8'h22);
    check("seg_idx1", 32'(seg), 32'h4F07);
    repeat (3) @(negedge fpga_clk);
    check("sel_hold_22", 32'(sel), 32'h22);
    @(negedge fpga_clk);
    check("sel_44", 32'(sel), 32'h44);
    check("seg_idx2", 32'(seg), 32'h5B7D);
    repeat (4) @(negedge fpga_clk);
    check("sel_88", 32'(sel), 32'h88);
    check("seg_idx3", 32'(seg), 32'h066D);
    repeat (4) @(negedge fpga_clk);
    check("sel_11", 32'(sel), 32'h11);
    check("seg_idx0_dp", 32'(seg), 32'h66FF);

    // 5: disable mid-digit, re-enable resumes at the running index
    wait_sel("scan_sync_44", 8'h44);
    bus_write(3'd5, 32'h0);
    @(negedge fpga_clk);
    check("dis_sel", 32'(sel), 32'h0);
    check("dis_seg", 32'(seg), 32'h0);
    bus_write(3'd5, 32'h11);
    @(negedge fpga_clk);
    check("resume_sel", 32'(sel), 32'h88);
    check("resume_seg", 32'(seg), 32'h066D);

    // 6: reserved words and writes to read-only words
    bus_write(3'd6, 32'hDEAD_BEEF);
    bus_write(3'd7, 32'hCAFE_F00D);
    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_write(3'd2, 32'h3);
    bus_read(3'd6, rd);
    check("rsv6_read", rd, 32'h0);
    bus_read(3'd7, rd);
    check("rsv7_read", rd, 32'h0);
    bus_read(3'd0, rd);
    check("ro_sw_data", rd, 32'h55);
    bus_read(3'd2, rd);
    check("ro_confirm", rd, 32'h0);
    bus_read(3'd3, rd);
    check("led_intact", rd, 32'hA5);
    bus_read(3'd4, rd);
    check("segval_intact", rd, 32'h1234_5678);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
